// File: rtl/grid_controller_pkg.sv
// ============================================================================
// Module : grid_controller_pkg
// Brief  : Board geometry, board type and controller state encoding
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grid_controller_pkg;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

    // grid[r] is row r; grid[r][c] is the cell at column c.
    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/grid_controller.sv
// ============================================================================
// Module : grid_controller
// Brief  : Owns the Game of Life board; row-serial load/readout and stepping
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_controller
    import grid_controller_pkg::*;
#(
    parameter int ROWS  = GRID_ROWS,
    parameter int COLS  = GRID_COLS,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [COLS-1:0]         load_row,
    input  logic                    load_last,
    input  logic                    rd_start,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [COLS-1:0]         rd_row,
    output logic [$clog2(ROWS)-1:0] rd_idx,
    output logic                    rd_last,
    input  logic                    step,
    input  logic                    run,
    output grid_t                   grid_q,
    input  grid_t                   grid_evolve,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    busy,
    output logic                    stable,
    output logic                    extinct
);

    localparam int                 c_IDX_W    = $clog2(ROWS);
    localparam logic [c_IDX_W-1:0] c_LAST_ROW = c_IDX_W'(ROWS - 1);

    ctrl_state_t        r_state, w_state_nxt;
    grid_t              r_grid,  w_grid_nxt;
    logic [c_IDX_W-1:0] r_ptr,   w_ptr_nxt;
    logic [GEN_W-1:0]   r_gen,   w_gen_nxt;
    logic               w_at_last_row;

    assign w_at_last_row = (r_ptr == c_LAST_ROW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grid  <= '0;
            r_ptr   <= '0;
            r_gen   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grid  <= w_grid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gen   <= w_gen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grid_nxt  = r_grid;
        w_ptr_nxt   = r_ptr;
        w_gen_nxt   = r_gen;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_grid_nxt  = '0;
                    w_gen_nxt   = '0;
                    w_ptr_nxt   = '0;
                    w_state_nxt = LOAD;
                end else if (rd_start) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = READ;
                end else if (step || run) begin
                    w_grid_nxt = grid_evolve;
                    w_gen_nxt  = r_gen + GEN_W'(1);
                end
            end
            LOAD: begin
                if (load_valid) begin
                    w_grid_nxt[r_ptr] = load_row;
                    w_ptr_nxt         = r_ptr + c_IDX_W'(1);
                    if (load_last || w_at_last_row) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                // The board is frozen here, so rows are served straight from r_grid.
                if (rd_ready) begin
                    w_ptr_nxt = r_ptr + c_IDX_W'(1);
                    if (w_at_last_row) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign load_ready = (r_state == LOAD);
    assign rd_valid   = (r_state == READ);
    assign rd_row     = r_grid[r_ptr];
    assign rd_idx     = r_ptr;
    assign rd_last    = (r_state == READ) && w_at_last_row;
    assign grid_q     = r_grid;
    assign gen_count  = r_gen;
    assign busy       = (r_state != IDLE);
    assign stable     = (grid_evolve == r_grid);
    assign extinct    = (r_grid == '0);

endmodule

`default_nettype wire

// File: tb/tb_grid_controller.sv
// ============================================================================
// Module : tb_grid_controller
// Brief  : Self-checking bench for grid_controller with a Life reference model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_controller;
    import grid_controller_pkg::*;

    localparam int ROWS  = GRID_ROWS;
    localparam int COLS  = GRID_COLS;
    localparam int IDX_W = $clog2(ROWS);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [COLS-1:0]  load_row = '0;
    logic             load_ready;
    logic             rd_start = 1'b0, rd_ready = 1'b0;
    logic             rd_valid, rd_last;
    logic [COLS-1:0]  rd_row;
    logic [IDX_W-1:0] rd_idx;
    logic             step = 1'b0, run = 1'b0;
    grid_t            grid_q, grid_evolve;
    logic [15:0]      gen_count;
    logic             busy, stable, extinct;

    int    checks = 0;
    int    errors = 0;
    grid_t m_grid;
    int    m_gen;

    grid_controller #(.ROWS(ROWS), .COLS(COLS), .GEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
        .load_row(load_row), .load_last(load_last),
        .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_row(rd_row), .rd_idx(rd_idx), .rd_last(rd_last),
        .step(step), .run(run),
        .grid_q(grid_q), .grid_evolve(grid_evolve),
        .gen_count(gen_count), .busy(busy), .stable(stable), .extinct(extinct)
    );

    always #5 clk = ~clk;

    // Conway's rules on a board whose outside is permanently dead.
    function automatic grid_t life(input grid_t g);
        grid_t n;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                            c + dc >= 0 && c + dc < COLS && g[r+dr][c+dc]) begin
                            cnt++;
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Stand-in for the datapath evolve block.
    always_comb grid_evolve = life(grid_q);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_board(input grid_t b, input int n, input bit use_last, input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_ready_in_load", load_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                load_row   = COLS'($urandom);
                tick();
            end
            load_valid = 1'b1;
            load_row   = b[i];
            load_last  = use_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        m_grid = '0;
        for (int i = 0; i < n; i++) m_grid[i] = b[i];
        m_gen = 0;
        chk("load_ready_after_exit", load_ready, 1'b0);
        chk("busy_after_load", busy, 1'b0);
        chk("grid_after_load", grid_q, m_grid);
        chk("gen_after_load", gen_count, 16'h0000);
    endtask

    task automatic advance(input int n, input bit use_run);
        if (use_run) begin
            run = 1'b1;
            repeat (n) tick();
            run = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                step = 1'b1;
                tick();
                step = 1'b0;
                if ($urandom_range(0, 1) == 1) tick();
            end
        end
        for (int i = 0; i < n; i++) m_grid = life(m_grid);
        m_gen = (m_gen + n) % 65536;
    endtask

    // mode 0: rd_ready pattern 1,0,0 repeating; mode 1: random. poke drives ignored inputs.
    task automatic readout(input int mode, input bit poke);
        int idx;
        int cyc;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < ROWS && cyc < 200) begin
            rd_ready = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (poke) begin
                step       = 1'($urandom_range(0, 1));
                load_start = 1'($urandom_range(0, 1));
                rd_start   = 1'($urandom_range(0, 1));
            end
            chk("rd_valid", rd_valid, 1'b1);
            chk("rd_idx", rd_idx, idx[IDX_W-1:0]);
            chk("rd_row", rd_row, m_grid[idx]);
            chk("rd_last", rd_last, idx == ROWS - 1);
            tick();
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready   = 1'b0;
        step       = 1'b0;
        load_start = 1'b0;
        rd_start   = 1'b0;
        chk("rd_transfers", idx, ROWS);
        chk("busy_after_read", busy, 1'b0);
        chk("rd_valid_after_read", rd_valid, 1'b0);
        chk("grid_after_read", grid_q, m_grid);
        chk("gen_after_read", gen_count, m_gen[15:0]);
    endtask

    typedef struct {
        grid_t       board;
        int          nrows;
        int          nsteps;
        bit          use_run;
        grid_t       exp_board;
        logic [15:0] exp_gen;
        bit          exp_stable_load;
        bit          exp_stable;
        bit          exp_extinct;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        grid_t b;

        // Blinker, one and two steps.
        b = '0; b[7] = 16'h0100; b[8] = 16'h0100; b[9] = 16'h0100;
        vecs[0].board = b; vecs[0].nrows = 10; vecs[0].nsteps = 1; vecs[0].use_run = 1'b0;
        vecs[0].exp_board = '0; vecs[0].exp_board[8] = 16'h0380; vecs[0].exp_gen = 16'd1;
        vecs[0].exp_stable_load = 1'b0; vecs[0].exp_stable = 1'b0; vecs[0].exp_extinct = 1'b0;
        vecs[1] = vecs[0]; vecs[1].nsteps = 2; vecs[1].exp_board = b; vecs[1].exp_gen = 16'd2;
        // Glider moving down-right, four generations under run.
        b = '0; b[0] = 16'h0002; b[1] = 16'h0004; b[2] = 16'h0007;
        vecs[2].board = b; vecs[2].nrows = 3; vecs[2].nsteps = 4; vecs[2].use_run = 1'b1;
        vecs[2].exp_board = '0; vecs[2].exp_board[1] = 16'h0004;
        vecs[2].exp_board[2] = 16'h0008; vecs[2].exp_board[3] = 16'h000E;
        vecs[2].exp_gen = 16'd4; vecs[2].exp_stable_load = 1'b0;
        vecs[2].exp_stable = 1'b0; vecs[2].exp_extinct = 1'b0;
        // Block still life.
        b = '0; b[4] = 16'h0030; b[5] = 16'h0030;
        vecs[3].board = b; vecs[3].nrows = 6; vecs[3].nsteps = 1; vecs[3].use_run = 1'b0;
        vecs[3].exp_board = b; vecs[3].exp_gen = 16'd1; vecs[3].exp_stable_load = 1'b1;
        vecs[3].exp_stable = 1'b1; vecs[3].exp_extinct = 1'b0;
        // Empty board.
        vecs[4].board = '0; vecs[4].nrows = 1; vecs[4].nsteps = 3; vecs[4].use_run = 1'b1;
        vecs[4].exp_board = '0; vecs[4].exp_gen = 16'd3; vecs[4].exp_stable_load = 1'b1;
        vecs[4].exp_stable = 1'b1; vecs[4].exp_extinct = 1'b1;

        // Reset state.
        tick();
        tick();
        chk("rst_grid", grid_q, 256'h0);
        chk("rst_gen", gen_count, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        reset = 1'b0;
        tick();

        // Reset mid-LOAD after five rows.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_row   = 16'hFFFF;
            tick();
        end
        load_valid = 1'b0;
        chk("midload_row4", grid_q[4], 16'hFFFF);
        chk("midload_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midload_rst_grid", grid_q, 256'h0);
        chk("midload_rst_busy", busy, 1'b0);
        chk("midload_rst_load_ready", load_ready, 1'b0);
        chk("midload_rst_gen", gen_count, 16'h0);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven patterns.
        for (int v = 0; v < 5; v++) begin
            load_board(vecs[v].board, vecs[v].nrows, 1'b1, 1'b0);
            chk("vec_stable_load", stable, vecs[v].exp_stable_load);
            advance(vecs[v].nsteps, vecs[v].use_run);
            chk("vec_board", grid_q, vecs[v].exp_board);
            chk("vec_model", grid_q, m_grid);
            chk("vec_gen", gen_count, vecs[v].exp_gen);
            chk("vec_stable", stable, vecs[v].exp_stable);
            chk("vec_extinct", extinct, vecs[v].exp_extinct);
        end

        // Readout with 1,0,0 backpressure, then with ignored inputs poked during READ.
        load_board(vecs[2].board, 3, 1'b1, 1'b0);
        advance(2, 1'b0);
        readout(0, 1'b0);
        readout(1, 1'b1);

        // Randomized loads, steps and readouts against the model.
        for (int it = 0; it < 12; it++) begin
            grid_t rb;
            int    n;
            bit    use_last;
            for (int r = 0; r < ROWS; r++) rb[r] = COLS'($urandom);
            n        = $urandom_range(1, ROWS);
            use_last = (n < ROWS) ? 1'b1 : 1'($urandom_range(0, 1));
            load_board(rb, n, use_last, 1'b1);
            // A row offered after the board is full must be ignored.
            load_valid = 1'b1;
            load_row   = 16'hA5A5;
            tick();
            load_valid = 1'b0;
            chk("rand_ignore_extra_row", grid_q, m_grid);
            advance($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            chk("rand_grid", grid_q, m_grid);
            chk("rand_gen", gen_count, m_gen[15:0]);
            chk("rand_stable", stable, life(m_grid) == m_grid);
            chk("rand_extinct", extinct, m_grid == '0);
            if (it % 3 == 0) readout(it % 2, 1'(it % 2));
        end

        // Generation counter wrap on an empty board.
        load_board('0, 1, 1'b1, 1'b0);
        run = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (i % 8192 == 0) begin
                chk("wrap_extinct", extinct, 1'b1);
                chk("wrap_stable", stable, 1'b1);
            end
        end
        run = 1'b0;
        chk("wrap_gen_max", gen_count, 16'hFFFF);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("wrap_gen_zero", gen_count, 16'h0000);
        chk("wrap_grid", grid_q, 256'h0);
        chk("wrap_extinct_end", extinct, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/grid_controller.md
Name: grid_controller

Overview:
- Sequential owner of the Game of Life board state; the stateful counterpart to the combinational `datapath` evolve block.
- Holds the current generation in a register, drives it to `datapath.grid`, and commits `datapath.grid_evolve` on each step.
- Also provides a row-serial load port (pattern in) and a row-serial readout port (board out, toward the display/host side).

Parameters:
- ROWS, 16, board rows; must equal the row count of grid_t.
- COLS, 16, board columns; must equal the column count of grid_t.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- load_start  in  1  pulse; begin loading a new pattern
- load_valid  in  1  load row valid
- load_ready  out  1  load row accepted when valid&ready
- load_row  in  COLS  row data; bit c = cell column c
- load_last  in  1  final row of pattern
- rd_start  in  1  pulse; begin board readout
- rd_valid  out  1  readout row valid
- rd_ready  in  1  readout sink ready
- rd_row  out  COLS  readout row data
- rd_idx  out  clog2(ROWS)  row index of rd_row
- rd_last  out  1  rd_row is row ROWS-1
- step  in  1  advance one generation
- run  in  1  level; advance every IDLE cycle
- grid_q  out  grid_t  current board, to datapath.grid
- grid_evolve  in  grid_t  next board, from datapath.grid_evolve
- gen_count  out  GEN_W  generations since last load
- busy  out  1  state != IDLE
- stable  out  1  grid_evolve == grid_q (combinational)
- extinct  out  1  grid_q == 0 (combinational)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, grid_q=0, gen_count=0, row pointer=0, rd_valid=0, load_ready=0. Reset mid-LOAD or mid-READ aborts to IDLE with the board cleared.
- FSM states: IDLE, LOAD, READ.
- IDLE priority: load_start > rd_start > (step|run).
  - load_start: grid_q<=0, gen_count<=0, ptr<=0, next state LOAD.
  - rd_start: ptr<=0, next state READ.
  - step|run: grid_q<=grid_evolve, gen_count<=gen_count+1 (wraps modulo 2^GEN_W). Latency is 1 cycle; the new board is visible on grid_q the cycle after step is sampled.
- LOAD:
  - load_ready=1.
  - On load_valid&load_ready: grid_q[ptr]<=load_row, ptr++.
  - Exit to IDLE after accepting the row with load_last=1, or after accepting row ROWS-1, whichever comes first.
  - Rows not written remain 0.
  - load_ready drops the cycle after the exit transfer.
- READ:
  - rd_valid=1, rd_row=grid_q[ptr], rd_idx=ptr, rd_last=(ptr==ROWS-1).
  - On rd_valid&rd_ready: ptr++. The transfer with rd_last=1 returns to IDLE.
  - While stalled (rd_ready=0), rd_row, rd_idx and rd_last are held stable.
  - Board is frozen, so no snapshot is needed.
- Ignored inputs:
  - step, run, load_start and rd_start outside IDLE are ignored, not queued.
  - load_valid outside LOAD is ignored.
- Row 0 = grid_q[0]; it is first in and first out.
- stable and extinct are valid every cycle, including during LOAD and READ.

Decomposition:
- Shared types package (existing types.sv) holds grid_t, GRID_ROWS and GRID_COLS. ROWS/COLS defaults derive from these.
- The package also gets ctrl_state_t enum {IDLE, LOAD, READ}.
- A single FSM module; no sub-module is required.
- The top-level wires grid_controller.grid_q → datapath.grid and datapath.grid_evolve → grid_controller.grid_evolve.

Test Plan:
- Reset mid-LOAD (after 5 rows) → grid_q=0, state IDLE, load_ready=0, gen_count=0 immediately on assert.
- Blinker: load rows 7,8,9 = bit 8 set with load_last on row 9 → remaining rows 0, busy falls. step×2 → gen_count=1 gives row 8 = bits 7,8,9; gen_count=2 restores the original. stable=0 throughout.
- Glider: load at rows 0-2, then run=1 for 4 cycles → pattern shifted +1 row, +1 column; gen_count=4; extinct=0. A 2×2 block loads with stable=1 and is unchanged after a step.
- Readout with backpressure: rd_start, rd_ready toggling 1,0,0,1… → exactly ROWS transfers, rd_idx 0..15 in order, rd_row held during stalls, rd_last only on idx 15, busy cleared after.
- Step or load_start asserted during READ → grid_q and gen_count unchanged, READ completes normally.
- gen_count wrap: preload gen_count to 0xFFFF via run on an empty board → the next step gives 0x0000. extinct=1 and stable=1 hold throughout.
